// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle RISC-V control FSM driving datapath selects, strobes and ALU operation.
// Optional macro BRANCH_EXT_EN adds bne/blt/bge/bltu/bgeu decode in BRANCH.
module multicycle_ctrl #(
    parameter int ALUCTL_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          op,
    input  logic [2:0]          funct3,
    input  logic                funct7b5,
    input  logic                memReady,
    input  logic                aluZero,
    input  logic                aluNeg,
    input  logic                aluCarry,
    input  logic                aluOverflow,
    output logic                pcWrite,
    output logic                adrSrc,
    output logic                memWrite,
    output logic                irWrite,
    output logic                regWrite,
    output logic [1:0]          resultSrc,
    output logic [1:0]          aluSrcA,
    output logic [1:0]          aluSrcB,
    output logic [2:0]          immSrc,
    output logic [ALUCTL_W-1:0] aluControl,
    output logic                illegal
);
    localparam logic [ALUCTL_W-1:0] ALU_ADD = ALUCTL_W'(0);
    localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(1);
    localparam logic [ALUCTL_W-1:0] ALU_AND = ALUCTL_W'(2);
    localparam logic [ALUCTL_W-1:0] ALU_OR  = ALUCTL_W'(3);
    localparam logic [ALUCTL_W-1:0] ALU_XOR = ALUCTL_W'(4);
    localparam logic [ALUCTL_W-1:0] ALU_SLL = ALUCTL_W'(5);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP
    } state_t;

    state_t state, state_n;
    logic [ALUCTL_W-1:0] alu_op;
    logic alu_ok, br_ok, taken;

    always_ff @(posedge clk)
        state <= reset ? FETCH : state_n;

    always_comb begin
        alu_ok = 1'b1;
        alu_op = ALU_ADD;
        case (funct3)
            3'b000:  alu_op = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_op = ALU_AND;
            3'b110:  alu_op = ALU_OR;
            3'b100:  alu_op = ALU_XOR;
            3'b001:  alu_op = ALU_SLL;
            default: alu_ok = 1'b0;
        endcase
    end

`ifdef BRANCH_EXT_EN
    always_comb begin
        br_ok = 1'b1;
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = aluZero;
            3'b001:  taken = ~aluZero;
            3'b100:  taken = aluNeg ^ aluOverflow;
            3'b101:  taken = ~(aluNeg ^ aluOverflow);
            3'b110:  taken = ~aluCarry;
            3'b111:  taken = aluCarry;
            default: br_ok = 1'b0;
        endcase
    end
`else
    assign br_ok = funct3 == 3'b000;
    assign taken = aluZero;
`endif

    // Outputs are forced to their idle values while reset is held, whatever the state.
    always_comb begin
        state_n    = state;
        pcWrite    = 1'b0;
        adrSrc     = 1'b0;
        memWrite   = 1'b0;
        irWrite    = 1'b0;
        regWrite   = 1'b0;
        resultSrc  = 2'b00;
        aluSrcA    = 2'b00;
        aluSrcB    = 2'b00;
        immSrc     = 3'b000;
        aluControl = ALU_ADD;
        illegal    = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    aluSrcB = 2'b10;
                    resultSrc = 2'b10;
                    irWrite = memReady;
                    pcWrite = memReady;
                    state_n = memReady ? DECODE : FETCH;
                end
                DECODE: begin
                    aluSrcA = 2'b01;
                    aluSrcB = 2'b01;
                    immSrc = 3'b010;
                    case (op)
                        7'b0000011, 7'b0100011: state_n = MEMADR;
                        7'b0110011: state_n = EXECR;
                        7'b0010011: state_n = EXECI;
                        7'b1100011: state_n = BRANCH;
                        7'b1101111: state_n = JAL;
                        default:    state_n = TRAP;
                    endcase
                end
                MEMADR: begin
                    aluSrcA = 2'b10;
                    aluSrcB = 2'b01;
                    immSrc = {2'b00, op[5]};
                    state_n = op[5] ? MEMWRITE : MEMREAD;
                end
                MEMREAD: begin
                    adrSrc = 1'b1;
                    state_n = memReady ? MEMWB : MEMREAD;
                end
                MEMWB: begin
                    resultSrc = 2'b01;
                    regWrite = 1'b1;
                    state_n = FETCH;
                end
                MEMWRITE: begin
                    adrSrc = 1'b1;
                    memWrite = 1'b1;
                    state_n = memReady ? FETCH : MEMWRITE;
                end
                EXECR: begin
                    aluSrcA = 2'b10;
                    aluControl = alu_op;
                    state_n = alu_ok ? ALUWB : TRAP;
                end
                EXECI: begin
                    aluSrcA = 2'b10;
                    aluSrcB = 2'b01;
                    aluControl = alu_op;
                    state_n = alu_ok ? ALUWB : TRAP;
                end
                ALUWB: begin
                    regWrite = 1'b1;
                    state_n = FETCH;
                end
                BRANCH: begin
                    aluSrcA = 2'b10;
                    aluControl = ALU_SUB;
                    pcWrite = br_ok & taken;
                    state_n = br_ok ? FETCH : TRAP;
                end
                JAL: begin
                    aluSrcA = 2'b01;
                    aluSrcB = 2'b10;
                    pcWrite = 1'b1;
                    state_n = ALUWB;
                end
                TRAP: illegal = 1'b1;
                default: state_n = FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven check of per-instruction behaviour plus hand-written multi-cycle corner cases.
module tb_multicycle_ctrl;
    localparam logic [4:0] A_ADD = 5'd0, A_SUB = 5'd1, A_AND = 5'd2, A_OR = 5'd3, A_XOR = 5'd4, A_SLL = 5'd5;

    logic clk = 1'b0, reset = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic funct7b5 = 1'b0, memReady = 1'b1;
    logic aluZero = 1'b0, aluNeg = 1'b0, aluCarry = 1'b0, aluOverflow = 1'b0;
    logic pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal;
    logic [1:0] resultSrc, aluSrcA, aluSrcB;
    logic [2:0] immSrc;
    logic [4:0] aluControl;
    int n_chk = 0, n_fail = 0;

    multicycle_ctrl #(.ALUCTL_W(5)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .memReady(memReady), .aluZero(aluZero), .aluNeg(aluNeg), .aluCarry(aluCarry),
        .aluOverflow(aluOverflow), .pcWrite(pcWrite), .adrSrc(adrSrc), .memWrite(memWrite),
        .irWrite(irWrite), .regWrite(regWrite), .resultSrc(resultSrc), .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB), .immSrc(immSrc), .aluControl(aluControl), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        logic [6:0] op;
        logic [2:0] f3;
        logic f7, z, n, c, v;
        int lat;
        logic [4:0] alu3;
        logic pcw3;
        int rw, mw;
        logic ill;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("reset_alu", 32'(aluControl), 32'(A_ADD));
        chk("reset_outs", 32'({pcWrite, adrSrc, memWrite, irWrite, regWrite, resultSrc,
                                aluSrcA, aluSrcB, immSrc, illegal}), 32'd0);
        tick();
        reset = 1'b0;
    endtask

    task automatic add_vec(input string name, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input logic n, input logic c, input logic v, input int lat,
                           input logic [4:0] alu3, input logic pcw3, input int rw, input int mw, input logic ill);
        vec_t t;
        t = '{name, o, f3, f7, z, n, c, v, lat, alu3, pcw3, rw, mw, ill};
        vecs.push_back(t);
    endtask

    initial begin
        int lat, rw, mw, held;
        logic ill_seen, pcw3;
        logic [4:0] alu3;
        add_vec("add",   7'b0110011, 3'b000, 0, 0, 0, 0, 0, 4, A_ADD, 0, 1, 0, 0);
        add_vec("sub",   7'b0110011, 3'b000, 1, 0, 0, 0, 0, 4, A_SUB, 0, 1, 0, 0);
        add_vec("addi7", 7'b0010011, 3'b000, 1, 0, 0, 0, 0, 4, A_ADD, 0, 1, 0, 0);
        add_vec("and",   7'b0110011, 3'b111, 0, 0, 0, 0, 0, 4, A_AND, 0, 1, 0, 0);
        add_vec("ori",   7'b0010011, 3'b110, 0, 0, 0, 0, 0, 4, A_OR,  0, 1, 0, 0);
        add_vec("xor",   7'b0110011, 3'b100, 0, 0, 0, 0, 0, 4, A_XOR, 0, 1, 0, 0);
        add_vec("slli",  7'b0010011, 3'b001, 0, 0, 0, 0, 0, 4, A_SLL, 0, 1, 0, 0);
        add_vec("r_f3bad", 7'b0110011, 3'b010, 0, 0, 0, 0, 0, 0, A_ADD, 0, 0, 0, 1);
        add_vec("lw",    7'b0000011, 3'b010, 0, 0, 0, 0, 0, 5, A_ADD, 0, 1, 0, 0);
        add_vec("sw",    7'b0100011, 3'b010, 0, 0, 0, 0, 0, 4, A_ADD, 0, 0, 1, 0);
        add_vec("beq_t", 7'b1100011, 3'b000, 0, 1, 0, 0, 0, 3, A_SUB, 1, 0, 0, 0);
        add_vec("beq_n", 7'b1100011, 3'b000, 0, 0, 0, 0, 0, 3, A_SUB, 0, 0, 0, 0);
        add_vec("jal",   7'b1101111, 3'b000, 0, 0, 0, 0, 0, 4, A_ADD, 1, 1, 0, 0);
        add_vec("op7f",  7'b1111111, 3'b000, 0, 0, 0, 0, 0, 0, A_ADD, 0, 0, 0, 1);
`ifdef BRANCH_EXT_EN
        add_vec("blt",   7'b1100011, 3'b100, 0, 0, 1, 0, 0, 3, A_SUB, 1, 0, 0, 0);
        add_vec("bne",   7'b1100011, 3'b001, 0, 0, 0, 0, 0, 3, A_SUB, 1, 0, 0, 0);
        add_vec("bltu",  7'b1100011, 3'b110, 0, 0, 0, 0, 0, 3, A_SUB, 1, 0, 0, 0);
        add_vec("bgeu",  7'b1100011, 3'b111, 0, 0, 0, 0, 0, 3, A_SUB, 0, 0, 0, 0);
        add_vec("bge",   7'b1100011, 3'b101, 0, 0, 1, 0, 1, 3, A_SUB, 1, 0, 0, 0);
        add_vec("b_f3bad", 7'b1100011, 3'b010, 0, 1, 0, 0, 0, 0, A_SUB, 0, 0, 0, 1);
`else
        add_vec("blt",   7'b1100011, 3'b100, 0, 0, 1, 0, 0, 0, A_SUB, 0, 0, 0, 1);
        add_vec("bne",   7'b1100011, 3'b001, 0, 0, 0, 0, 0, 0, A_SUB, 0, 0, 0, 1);
`endif
        tick();
        do_reset();
        foreach (vecs[i]) begin
            op = vecs[i].op; funct3 = vecs[i].f3; funct7b5 = vecs[i].f7;
            aluZero = vecs[i].z; aluNeg = vecs[i].n; aluCarry = vecs[i].c; aluOverflow = vecs[i].v;
            memReady = 1'b1;
            lat = 0; rw = 0; mw = 0; ill_seen = 1'b0; alu3 = '0; pcw3 = 1'b0;
            for (int cyc = 1; cyc <= 12; cyc++) begin
                #1;
                if (cyc > 1 && irWrite) begin
                    lat = cyc - 1;
                    break;
                end
                rw += int'(regWrite);
                mw += int'(memWrite);
                ill_seen |= illegal;
                if (cyc == 3) begin
                    alu3 = aluControl;
                    pcw3 = pcWrite;
                end
                tick();
            end
            chk({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
            chk({vecs[i].name, "_alu"}, 32'(alu3), 32'(vecs[i].alu3));
            chk({vecs[i].name, "_pcw"}, 32'(pcw3), 32'(vecs[i].pcw3));
            chk({vecs[i].name, "_rw"}, 32'(rw), 32'(vecs[i].rw));
            chk({vecs[i].name, "_mw"}, 32'(mw), 32'(vecs[i].mw));
            chk({vecs[i].name, "_ill"}, 32'(ill_seen), 32'(vecs[i].ill));
            do_reset();
        end

        // Load with three wait cycles in MEMREAD.
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
        held = 0; rw = 0;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            memReady = !(cyc >= 4 && cyc <= 6);
            #1;
            held += int'(adrSrc);
            rw += int'(regWrite);
            if (cyc == 8) chk("lw_wait_wb_rs", 32'(resultSrc), 32'd1);
            tick();
        end
        chk("lw_wait_adr", 32'(held), 32'd4);
        chk("lw_wait_rw", 32'(rw), 32'd1);
        do_reset();

        // Unsupported opcode: illegal sticks until reset.
        op = 7'b1111111; memReady = 1'b1;
        tick(); tick();
        held = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            #1;
            held += int'(illegal && !(pcWrite | memWrite | irWrite | regWrite));
            tick();
        end
        chk("trap_held", 32'(held), 32'd10);
        do_reset();
        memReady = 1'b0;
        #1;
        chk("trap_clr_ill", 32'(illegal), 32'd0);
        chk("trap_clr_fetch", 32'({irWrite, aluSrcB, resultSrc}), 32'b01010);

        // Reset in the middle of a stalled store.
        op = 7'b0100011; funct3 = 3'b010;
        tick();
        for (int cyc = 1; cyc <= 4; cyc++) begin
            memReady = cyc < 4;
            #1;
            if (cyc == 4) chk("sw_stall", 32'({memWrite, adrSrc}), 32'b11);
            tick();
        end
        do_reset();
        #1;
        chk("sw_rst_fetch", 32'({memWrite, adrSrc, irWrite, aluSrcB}), 32'b00010);
        tick(); tick();
        #1;
        chk("fetch_hold", 32'({irWrite, pcWrite, aluSrcB}), 32'b0010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter: ALUCTL_W, default 5, width of aluControl; matches the ALU_* codes in alu.vh.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- op  in  7  instruction opcode.
- funct3  in  3  instruction funct3.
- funct7b5  in  1  instruction bit 30.
- memReady  in  1  memory access complete this cycle.
- aluZero  in  1  ALU flag.
- aluNeg  in  1  ALU flag.
- aluCarry  in  1  ALU flag.
- aluOverflow  in  1  ALU flag.
- pcWrite  out  1  PC load enable.
- adrSrc  out  1  memory address select: 0=PC, 1=ALU register.
- memWrite  out  1  store strobe.
- irWrite  out  1  instruction register load.
- regWrite  out  1  register file write.
- resultSrc  out  2  result select: 00=ALU register, 01=data register, 10=ALU result.
- aluSrcA  out  2  ALU A select: 00=PC, 01=oldPC, 10=rs1.
- aluSrcB  out  2  ALU B select: 00=rs2, 01=immediate, 10=constant 4.
- immSrc  out  3  immediate type: 000=I, 001=S, 010=B, 011=J.
- aluControl  out  ALUCTL_W  ALU operation code driving alu.aluControl.
- illegal  out  1  sticky unsupported-opcode indicator.

Function
REQ-003 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP.
REQ-004 SHALL set all strobes (pcWrite, memWrite, irWrite, regWrite) to 0 unless the current state asserts them.
REQ-005 FETCH SHALL drive adrSrc=0; while memReady=0, hold FETCH; on memReady=1, pulse irWrite=1 and pcWrite=1 with aluSrcA=00, aluSrcB=10, aluControl=ALU_ADD, resultSrc=10, then go to DECODE.
REQ-006 DECODE SHALL compute oldPC+imm (aluSrcA=01, aluSrcB=01, immSrc=010, ALU_ADD) and branch on op: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; any other -> TRAP.
REQ-007 MEMADR SHALL compute rs1+imm (aluSrcA=10, aluSrcB=01, immSrc=000 for loads, 001 for stores, ALU_ADD) and go to MEMREAD for loads or MEMWRITE for stores.
REQ-008 MEMREAD SHALL drive adrSrc=1 and resultSrc=00, holding until memReady=1, then go to MEMWB.
REQ-009 MEMWRITE SHALL drive adrSrc=1 and memWrite=1 until memReady=1, then go to FETCH; memWrite SHALL deassert in the cycle after memReady.
REQ-010 MEMWB SHALL drive resultSrc=01 and regWrite=1 for one cycle, then go to FETCH.
REQ-011 EXECR/EXECI SHALL drive aluSrcA=10 and aluSrcB=00 (EXECR) or 01 (EXECI, immSrc=000), then go to ALUWB; ALUWB SHALL drive resultSrc=00 and regWrite=1 for one cycle, then go to FETCH.
REQ-012 ALU decode in EXECR/EXECI SHALL map funct3 as follows: 000 -> ALU_SUB if (op[5] & funct7b5), else ALU_ADD; 111 -> ALU_AND; 110 -> ALU_OR; 100 -> ALU_XOR; 001 -> ALU_SLL; any other funct3 -> TRAP.
REQ-013 BRANCH SHALL drive aluSrcA=10, aluSrcB=00, ALU_SUB and resultSrc=00, set pcWrite=taken, then go to FETCH; beq: taken=aluZero.
REQ-014 JAL SHALL drive aluSrcA=01, aluSrcB=10, ALU_ADD, resultSrc=00 and pcWrite=1, then go to ALUWB.
REQ-015 TRAP SHALL set illegal=1, hold all strobes at 0, and remain in TRAP until reset.
REQ-016 Latencies with memReady tied to 1 SHALL be: R/I-type 4 cycles, load 5, store 4, branch 3, jal 4.

Reset
REQ-017 reset=1 at any clock edge, including mid-access, SHALL force state FETCH, illegal=0 and all strobes 0 in the following cycle.
REQ-018 During reset, all outputs SHALL be 0 except aluControl=ALU_ADD.

Configuration
REQ-019 Macro BRANCH_EXT_EN defined: BRANCH SHALL also decode funct3 001 bne (taken=~aluZero), 100 blt (taken=aluNeg^aluOverflow), 101 bge (taken=~(aluNeg^aluOverflow)), 110 bltu (taken=~aluCarry), 111 bgeu (taken=aluCarry); funct3 010/011 -> TRAP.
REQ-020 Macro BRANCH_EXT_EN undefined: only funct3=000 is legal in BRANCH; any other funct3 -> TRAP.

Verification
REQ-021 add x (op=0110011, funct3=000, funct7b5=0), memReady=1 -> states FETCH, DECODE, EXECR, ALUWB; aluControl=ALU_ADD in EXECR; regWrite=1 only in cycle 4.
REQ-022 Load with memReady low for 3 cycles in MEMREAD -> adrSrc=1 held 4 cycles; regWrite=1 exactly once, in MEMWB.
REQ-023 beq with aluZero=1, then with aluZero=0 -> pcWrite=1 in BRANCH, then pcWrite=0 in BRANCH.
REQ-024 sub (funct7b5=1, op[5]=1) -> ALU_SUB; addi with funct7b5=1 (op[5]=0) -> ALU_ADD.
REQ-025 op=1111111 -> TRAP with illegal=1 held 10 cycles; reset pulse -> FETCH with illegal=0.
REQ-026 blt with aluNeg=1, aluOverflow=0 -> pcWrite=1 when BRANCH_EXT_EN is defined; TRAP when it is undefined.
